// File: rtl/hart_scheduler.sv
// Quantum-based round-robin owner selection for the shared memory/MMU port.
// Switches only at owner-declared safe points while the controller is in CPU mode.
module hart_scheduler #(
  parameter int unsigned N_HARTS       = 2,
  parameter int unsigned QUANTUM       = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  localparam int unsigned SW           = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               w_mode_is_cpu,
  input  logic               w_next_mode_is_mc,
  input  logic [N_HARTS-1:0] w_hart_active,
  input  logic [N_HARTS-1:0] w_hart_safe,
  input  logic [N_HARTS-1:0] w_hart_tick,
  output logic [SW-1:0]      r_hart_sel,
  output logic [N_HARTS-1:0] w_grant,
  output logic               w_hold,
  output logic               r_switch,
  output logic               r_drain_timeout
);

  localparam int unsigned CW = $clog2(QUANTUM + 1);
  localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] QMax = CW'(QUANTUM);
  localparam logic [DW-1:0] DMax = DW'(DRAIN_TIMEOUT);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StSwitch = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SW-1:0]      sel_q, sel_d, next_sel, idx;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0]      dcnt_q, dcnt_d, dcnt_inc;
  logic               switch_q, switch_d;
  logic               timeout_q, timeout_d;
  logic [N_HARTS-1:0] grant;
  logic               other, owner_active, owner_tick, owner_safe, may_switch;

  always_comb begin
    grant        = '0;
    grant[sel_q] = 1'b1;
  end

  // Owner bits are picked through the grant mask so no variable index is needed.
  assign other        = |(w_hart_active & ~grant);
  assign owner_active = |(w_hart_active & grant);
  assign owner_tick   = |(w_hart_tick & grant);
  assign owner_safe   = |(w_hart_safe & grant);
  assign may_switch   = owner_safe && w_mode_is_cpu && !w_next_mode_is_mc && other;

  // Scan downward so the nearest active hart after the owner wins.
  always_comb begin
    next_sel = sel_q;
    idx      = sel_q;
    for (int k = int'(N_HARTS) - 1; k >= 1; k--) begin
      idx = SW'((int'(sel_q) + k) % int'(N_HARTS));
      if (w_hart_active[idx]) next_sel = idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    switch_d  = 1'b0;
    timeout_d = timeout_q;
    cnt_inc   = (owner_tick && cnt_q != QMax) ? cnt_q + CW'(1) : cnt_q;
    dcnt_inc  = (dcnt_q != DMax) ? dcnt_q + DW'(1) : dcnt_q;
    case (state_q)
      StRun: begin
        cnt_d = cnt_inc;
        if ((cnt_inc == QMax || !owner_active) && other) state_d = StDrain;
      end
      StDrain: begin
        if (!other) begin
          state_d = StRun;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_inc;
          if (dcnt_inc == DMax) timeout_d = 1'b1;
          if (may_switch) begin
            state_d  = StSwitch;
            sel_d    = next_sel;
            switch_d = 1'b1;
          end
        end
      end
      StSwitch: begin
        state_d = StRun;
        cnt_d   = '0;
        dcnt_d  = '0;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StRun;
      sel_q     <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      switch_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      switch_q  <= switch_d;
      timeout_q <= timeout_d;
    end
  end

  assign r_hart_sel      = sel_q;
  assign w_grant         = grant;
  assign w_hold          = (state_q == StSwitch);
  assign r_switch        = switch_q;
  assign r_drain_timeout = timeout_q;

endmodule

// File: tb/tb_hart_scheduler.sv
// Bench for hart_scheduler: directed table and sequences, then random stimulus
// against a behavioural owner/quantum/drain model.
module tb_hart_scheduler;
  localparam int N = 4;
  localparam int Q = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu, nextmc;
  logic [3:0] act, safe, tick;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       hold, sw, to;
  logic       sel1, grant1, hold1, sw1, to1;
  logic [8:0] obs;
  int         total = 0;
  int         bad = 0;
  int         got;

  always #5 clk = ~clk;

  hart_scheduler #(.N_HARTS(N), .QUANTUM(Q), .DRAIN_TIMEOUT(T)) u_dut (
    .CLK(clk), .RST(rst), .w_mode_is_cpu(cpu), .w_next_mode_is_mc(nextmc),
    .w_hart_active(act), .w_hart_safe(safe), .w_hart_tick(tick),
    .r_hart_sel(sel), .w_grant(grant), .w_hold(hold), .r_switch(sw),
    .r_drain_timeout(to)
  );

  hart_scheduler #(.N_HARTS(1), .QUANTUM(2), .DRAIN_TIMEOUT(3)) u_one (
    .CLK(clk), .RST(rst), .w_mode_is_cpu(cpu), .w_next_mode_is_mc(nextmc),
    .w_hart_active(act[0]), .w_hart_safe(safe[0]), .w_hart_tick(tick[0]),
    .r_hart_sel(sel1), .w_grant(grant1), .w_hold(hold1), .r_switch(sw1),
    .r_drain_timeout(to1)
  );

  assign obs = {to, sw, hold, grant, sel};

  typedef struct {
    logic [3:0] act, safe, tick;
    logic       cpu, mc;
    int         sel;
    bit         hold, sw, to;
  } vec_t;
  vec_t tbl[12];

  typedef enum {MRun, MDrain, MSwitch} phase_t;
  phase_t m_phase;
  int     m_owner, m_used, m_drain;
  bit     m_sw, m_to;

  function automatic logic [8:0] exp_out(input int s, input bit h, input bit w, input bit t);
    logic [3:0] g;
    g = 4'(1) << s;
    return {t, w, h, g, 2'(s)};
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] s, input logic [3:0] k,
                       input logic c, input logic m);
    act = a; safe = s; tick = k; cpu = c; nextmc = m;
  endtask

  task automatic quantum(input logic [3:0] k, output int owner);
    drive(4'b1011, 4'b1111, k, 1'b1, 1'b0);
    repeat (Q) step();
    tick = 4'b0000;
    owner = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (sw) begin
        owner = int'(sel);
        break;
      end
    end
    step();
  endtask

  task automatic model_reset();
    m_phase = MRun; m_owner = 0; m_used = 0; m_drain = 0; m_sw = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [3:0] s, input logic [3:0] k,
                            input logic c, input logic m);
    bit others;
    int nx;
    others = 0;
    for (int j = 0; j < N; j++) if (j != m_owner && a[j]) others = 1;
    m_sw = 0;
    case (m_phase)
      MSwitch: begin
        m_phase = MRun; m_used = 0; m_drain = 0;
      end
      MRun: begin
        if (k[m_owner] && m_used < Q) m_used++;
        if ((m_used == Q || !a[m_owner]) && others) m_phase = MDrain;
      end
      MDrain: begin
        if (!others) begin
          m_phase = MRun; m_drain = 0;
        end else begin
          if (m_drain < T) m_drain++;
          if (m_drain == T) m_to = 1;
          if (s[m_owner] && c && !m) begin
            nx = (m_owner + 1) % N;
            while (!a[nx]) nx = (nx + 1) % N;
            m_owner = nx; m_phase = MSwitch; m_sw = 1;
          end
        end
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].act = 4'b0011; tbl[i].safe = 4'b0011; tbl[i].tick = 4'b0001;
      tbl[i].cpu = 1'b1; tbl[i].mc = 1'b0;
      tbl[i].sel = (i < 4) ? 0 : 1;
      tbl[i].hold = (i == 4); tbl[i].sw = (i == 4); tbl[i].to = 1'b0;
    end

    rst = 1'b1;
    drive(4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0);
    #12;
    check("reset", obs, exp_out(0, 0, 0, 0));
    check("reset_one", {to1, sw1, hold1, grant1, sel1}, 5'b00010);
    @(negedge clk);
    rst = 1'b0;

    // Quantum expiry on hart 0, one drain cycle, switch, then hart 0 ticks ignored.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].act, tbl[i].safe, tbl[i].tick, tbl[i].cpu, tbl[i].mc);
      step();
      check($sformatf("vec%0d", i), obs, exp_out(tbl[i].sel, tbl[i].hold, tbl[i].sw, tbl[i].to));
    end

    // Mode gating: three non-CPU cycles, one next_mode_is_mc cycle, then switch.
    drive(4'b0011, 4'b0011, 4'b0010, 1'b0, 1'b0);
    repeat (Q) step();
    tick = 4'b0000;
    repeat (3) begin
      step();
      check("mode_wait", obs, exp_out(1, 0, 0, 0));
    end
    cpu = 1'b1; nextmc = 1'b1;
    step();
    check("mc_blocks", obs, exp_out(1, 0, 0, 0));
    nextmc = 1'b0;
    step();
    check("mode_switch", obs, exp_out(0, 1, 1, 0));
    step();
    check("mode_run", obs, exp_out(0, 0, 0, 0));

    // Skip inactive hart 2 and wrap 3 -> 0.
    quantum(4'b0001, got);
    check("next_0_1", got, 1);
    quantum(4'b0010, got);
    check("skip_2", got, 3);
    quantum(4'b1000, got);
    check("wrap_3_0", got, 0);

    // Drain timeout with safe held low for ten drain cycles.
    drive(4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0);
    repeat (Q) step();
    tick = 4'b0000;
    repeat (7) step();
    check("to_7", to, 0);
    step();
    check("to_8", to, 1);
    repeat (2) step();
    check("to_hold_owner", obs, exp_out(0, 0, 0, 1));
    safe = 4'b0001;
    step();
    check("to_switch", obs, exp_out(1, 1, 1, 1));
    step();
    check("to_sticky", obs, exp_out(1, 0, 0, 1));

    // Reset in the middle of a SWITCH cycle to hart 2.
    rst = 1'b1;
    #1;
    check("rst_clears_to", obs, exp_out(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0101, 4'b1111, 4'b0001, 1'b1, 1'b0);
    repeat (Q) step();
    tick = 4'b0000;
    step();
    check("switch_to_2", obs, exp_out(2, 1, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_switch", obs, exp_out(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    step();
    check("after_rst", obs, exp_out(0, 0, 0, 0));

    // Random stimulus against the model.
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 499) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("rnd_reset", obs, exp_out(0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
      end
      for (int j = 0; j < N; j++) begin
        act[j]  = ($urandom_range(3) != 0);
        safe[j] = ($urandom_range(1) != 0);
        tick[j] = ($urandom_range(1) != 0);
      end
      cpu    = ($urandom_range(4) != 0);
      nextmc = ($urandom_range(4) == 0);
      @(posedge clk);
      model_step(act, safe, tick, cpu, nextmc);
      #1;
      check($sformatf("rnd%0d", i), obs, exp_out(m_owner, m_phase == MSwitch, m_sw, m_to));
      check("one_hart", {sw1, hold1, grant1, sel1}, 4'b0010);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hart_scheduler.md
# hart_scheduler

Time-slicing scheduler for the SMP core cluster. It decides which hart owns the shared instruction/data memory port, MMU port and DRAM-busy path. It switches only at hart-declared safe points, and only while the memory controller is in CPU mode. It replaces the ad-hoc per-branch hart rotation with a quantum-based round-robin that skips idle harts and flags harts that fail to drain. The cluster uses `r_hart_sel` and `w_grant` to steer its output muxes and the per-core busy forcing.

## Interface

Parameters:
- N_HARTS, 2, number of harts arbitrated (1..16).
- QUANTUM, 16, tick count a hart keeps the port before yielding (≥1).
- DRAIN_TIMEOUT, 1024, drain cycles before the timeout flag sets (≥1).

Ports (SW = max(1, ceil(log2 N_HARTS))):
- Reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- w_mode_is_cpu  in  1  memory controller is serving CPU traffic.
- w_next_mode_is_mc  in  1  memory controller leaves CPU mode next cycle.
- w_hart_active  in  N_HARTS  hart is runnable (not halted, not in WFI).
- w_hart_safe  in  N_HARTS  hart is at a switch-safe point this cycle (next_state idle, no CSR op in EX/MEM, no exception being taken).
- w_hart_tick  in  N_HARTS  quantum tick pulse (taken control transfer retired).
- r_hart_sel  out  SW  index of the owning hart.
- w_grant  out  N_HARTS  one-hot decode of r_hart_sel.
- w_hold  out  1  high in SWITCH; the cluster forces busy to every core.
- r_switch  out  1  one-cycle pulse coinciding with the first cycle of the new owner.
- r_drain_timeout  out  1  sticky error flag; cleared only by RST.

## Operation

- State machine states: RUN, DRAIN, SWITCH. Internal quantum counter `cnt` (saturating at QUANTUM). Internal drain counter `dcnt` (saturating at DRAIN_TIMEOUT).
- `other` means some hart j ≠ r_hart_sel has w_hart_active[j] = 1.
- `next` is the first hart with w_hart_active = 1, scanning r_hart_sel+1, r_hart_sel+2, … modulo N_HARTS (wrap N_HARTS-1 → 0), excluding r_hart_sel.
- RUN behaviour:
  - cnt increments on w_hart_tick[r_hart_sel]; ticks from other harts are ignored.
  - Go to DRAIN when (cnt == QUANTUM or !w_hart_active[r_hart_sel]) and `other`.
  - If no `other`, stay in RUN with cnt held saturated.
- DRAIN behaviour:
  - The owner keeps running; dcnt increments every cycle.
  - Switch condition: w_hart_safe[r_hart_sel] && w_mode_is_cpu && !w_next_mode_is_mc && `other`. When it holds: go to SWITCH, load r_hart_sel ← next, set r_switch ← 1.
  - If `other` drops to 0, return to RUN; cnt is unchanged and dcnt is cleared.
  - When dcnt reaches DRAIN_TIMEOUT, r_drain_timeout ← 1; the scheduler keeps waiting and never forces a switch.
- SWITCH behaviour: lasts exactly one cycle with w_hold = 1. Then go to RUN with cnt ← 0, dcnt ← 0 and r_switch ← 0. Ticks during SWITCH are ignored.
- If the owner becomes inactive and no other hart is active, ownership stays put (no idle owner state).
- N_HARTS = 1: the block never leaves RUN; r_hart_sel is constant 0 and r_switch / w_hold are never asserted.
- w_hold is decoded from state; w_grant is decoded from r_hart_sel.

## Timing

- Reset (asynchronous, takes effect immediately):
  - r_hart_sel = 0, w_grant = 1 (hart 0), state RUN, cnt = 0, dcnt = 0.
  - r_switch = 0, w_hold = 0, r_drain_timeout = 0.
- Quantum expiry: the tick that makes cnt == QUANTUM is sampled at edge t. State is DRAIN from cycle t+1.
- Drain: the switch condition first true in cycle d is sampled at edge d. Cycle d+1 is SWITCH: r_hart_sel is already new, r_switch = 1, w_hold = 1. Cycle d+2 is RUN, and the new owner's ticks count from d+2.
- Minimum switch latency: entry to DRAIN at t+1 with safe already high gives the new owner at t+2.
- Simultaneous events in DRAIN: w_next_mode_is_mc = 1 blocks the switch even when safe = 1. The switch is retried on the next qualifying cycle.
- Reset asserted mid-DRAIN or mid-SWITCH: all reset values apply immediately, with no pending switch retained.

## Test plan

- N_HARTS=2, QUANTUM=4, both active, safe=1, one tick per cycle on hart 0 → after the 4th tick, DRAIN for one cycle. Then one cycle with r_hart_sel=1, r_switch=1, w_hold=1. Then RUN, and hart-0 ticks are ignored.
- Only hart 0 active, 20 ticks → r_hart_sel stays 0; r_switch and w_hold are never asserted.
- Quantum expired; safe=1 but w_mode_is_cpu=0 for 3 cycles, then w_next_mode_is_mc=1 for 1 cycle, then both qualifying → switch exactly one cycle after the first fully qualifying cycle.
- N_HARTS=4, owner 1, hart 2 inactive, harts 0 and 3 active → next owner is 3. After the following quantum, ownership wraps to 0.
- DRAIN_TIMEOUT=8, safe held low 10 cycles → r_drain_timeout=1 after 8 DRAIN cycles. The switch still follows when safe rises, and the flag stays 1 until RST.
- RST pulsed during the SWITCH cycle with r_hart_sel=2 → immediately r_hart_sel=0, w_grant=0001, w_hold=0, r_switch=0.
